// File: rtl/id_ex_fwd_stage_if.sv
// rtl/id_ex_fwd_stage_if.sv - ID/EX boundary signal bundle (HAZARD_STATS_EN adds stats counters)
interface id_ex_fwd_stage_if #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4,
  parameter int OPC_W  = 4
);
  logic              id_valid;
  logic [OPC_W-1:0]  id_opcode;
  logic [REG_W-1:0]  id_dst;
  logic              id_rf_wr;
  logic [DATA_W-1:0] id_rdata1;
  logic [DATA_W-1:0] id_rdata2;
  logic              stall;
  logic              flush;
  logic              xx_reg1;
  logic              xx_reg2;
  logic              mx_reg1;
  logic              mx_reg2;
  logic [DATA_W-1:0] exmem_result;
  logic [DATA_W-1:0] memwb_result;
  logic              pc_hold;
  logic              ex_valid;
  logic [OPC_W-1:0]  ex_opcode;
  logic [REG_W-1:0]  ex_dst;
  logic              ex_rf_wr;
  logic [DATA_W-1:0] ex_opA;
  logic [DATA_W-1:0] ex_opB;
`ifdef HAZARD_STATS_EN
  logic [15:0]       stall_cnt;
  logic [15:0]       fwd_cnt;
`endif

  // ID stage / hazard unit side: drives decode and forwarding, observes EX
  modport master (
    output id_valid, id_opcode, id_dst, id_rf_wr, id_rdata1, id_rdata2,
    output stall, flush, xx_reg1, xx_reg2, mx_reg1, mx_reg2,
    output exmem_result, memwb_result,
`ifdef HAZARD_STATS_EN
    input  stall_cnt, fwd_cnt,
`endif
    input  pc_hold, ex_valid, ex_opcode, ex_dst, ex_rf_wr, ex_opA, ex_opB
  );

  // Pipeline stage side
  modport slave (
    input  id_valid, id_opcode, id_dst, id_rf_wr, id_rdata1, id_rdata2,
    input  stall, flush, xx_reg1, xx_reg2, mx_reg1, mx_reg2,
    input  exmem_result, memwb_result,
`ifdef HAZARD_STATS_EN
    output stall_cnt, fwd_cnt,
`endif
    output pc_hold, ex_valid, ex_opcode, ex_dst, ex_rf_wr, ex_opA, ex_opB
  );
endinterface

// File: rtl/id_ex_fwd_stage.sv
// rtl/id_ex_fwd_stage.sv - ID/EX register with operand forwarding, stall bubbles and flush (HAZARD_STATS_EN adds counters)
module id_ex_fwd_stage #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4,
  parameter int OPC_W  = 4
) (
  input logic           clk,
  input logic           rst,
  id_ex_fwd_stage_if.slave bus
);

  logic              valid_q;
  logic [OPC_W-1:0]  opcode_q;
  logic [REG_W-1:0]  dst_q;
  logic              rf_wr_q;
  logic [DATA_W-1:0] rdata1_q;
  logic [DATA_W-1:0] rdata2_q;
  logic [1:0]        sel1_q;   // {xx, mx}
  logic [1:0]        sel2_q;   // {xx, mx}
  logic              bubble;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  // A stall or a flush both turn the next EX slot into a bubble
  assign bubble = bus.stall | bus.flush;

  // ID/EX register: reset dominates, then bubble, else capture ID
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      valid_q  <= 1'b0;
      opcode_q <= '0;
      dst_q    <= '0;
      rf_wr_q  <= 1'b0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      sel1_q   <= 2'b00;
      sel2_q   <= 2'b00;
    end else begin
      valid_q  <= bus.id_valid;
      opcode_q <= bus.id_opcode;
      dst_q    <= bus.id_dst;
      rf_wr_q  <= bus.id_rf_wr & bus.id_valid;
      rdata1_q <= bus.id_rdata1;
      rdata2_q <= bus.id_rdata2;
      sel1_q   <= {bus.xx_reg1, bus.mx_reg1};
      sel2_q   <= {bus.xx_reg2, bus.mx_reg2};
    end
  end

  // Operand muxes: EX/MEM is the newer producer so it beats MEM/WB
  always_comb begin
    op_a = rdata1_q;
    op_b = rdata2_q;
    if (sel1_q[1])      op_a = bus.exmem_result;
    else if (sel1_q[0]) op_a = bus.memwb_result;
    if (sel2_q[1])      op_b = bus.exmem_result;
    else if (sel2_q[0]) op_b = bus.memwb_result;
  end

  // Flush overrides stall: redirected fetch must not be frozen
  assign bus.pc_hold   = bus.stall & ~bus.flush;
  assign bus.ex_valid  = valid_q;
  assign bus.ex_opcode = opcode_q;
  assign bus.ex_dst    = dst_q;
  assign bus.ex_rf_wr  = rf_wr_q & valid_q;
  assign bus.ex_opA    = op_a;
  assign bus.ex_opB    = op_b;

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] fwd_cnt_q;

  // Saturating hazard counters: held stalls and forwarded EX instructions
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (bus.stall && !bus.flush && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (valid_q && (sel1_q != 2'b00 || sel2_q != 2'b00) && fwd_cnt_q != 16'hFFFF)
        fwd_cnt_q <= fwd_cnt_q + 16'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// tb/tb_id_ex_fwd_stage.sv - scoreboard bench for id_ex_fwd_stage
module tb_id_ex_fwd_stage;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  id_ex_fwd_stage_if #(.DATA_W(16), .REG_W(4), .OPC_W(4)) bus ();

  id_ex_fwd_stage #(.DATA_W(16), .REG_W(4), .OPC_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        hold;
    logic        valid;
    logic        wr;
    logic [3:0]  opc;
    logic [3:0]  dst;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Inputs for one cycle are applied at the falling edge; the expected
  // outputs for that same cycle (before the next capture) are queued.
  // sels = {xx1, mx1, xx2, mx2}
  task automatic drive(
    input logic r, input logic v, input logic [3:0] opc, input logic [3:0] dst,
    input logic wr, input logic [15:0] r1, input logic [15:0] r2,
    input logic st, input logic fl, input logic [3:0] sels,
    input logic [15:0] exm, input logic [15:0] mwb, input logic chk,
    input logic e_hold, input logic e_valid, input logic e_wr,
    input logic [3:0] e_opc, input logic [3:0] e_dst,
    input logic [15:0] e_a, input logic [15:0] e_b);
    exp_t e;
    @(negedge clk);
    rst              = r;
    bus.id_valid     = v;
    bus.id_opcode    = opc;
    bus.id_dst       = dst;
    bus.id_rf_wr     = wr;
    bus.id_rdata1    = r1;
    bus.id_rdata2    = r2;
    bus.stall        = st;
    bus.flush        = fl;
    bus.xx_reg1      = sels[3];
    bus.mx_reg1      = sels[2];
    bus.xx_reg2      = sels[1];
    bus.mx_reg2      = sels[0];
    bus.exmem_result = exm;
    bus.memwb_result = mwb;
    if (chk) begin
      e.hold = e_hold; e.valid = e_valid; e.wr = e_wr;
      e.opc = e_opc; e.dst = e_dst; e.a = e_a; e.b = e_b;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: pops one expectation per presented cycle, mid-low-phase
  always @(negedge clk) begin
    #2;
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("pc_hold",   {15'd0, bus.pc_hold},  {15'd0, e.hold});
      check("ex_valid",  {15'd0, bus.ex_valid}, {15'd0, e.valid});
      check("ex_rf_wr",  {15'd0, bus.ex_rf_wr}, {15'd0, e.wr});
      check("ex_opcode", {12'd0, bus.ex_opcode}, {12'd0, e.opc});
      check("ex_dst",    {12'd0, bus.ex_dst},   {12'd0, e.dst});
      check("ex_opA",    bus.ex_opA, e.a);
      check("ex_opB",    bus.ex_opB, e.b);
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    //    r  v  opc  dst  wr r1        r2        st fl sels     exm       mwb      chk  hold vld wr opc  dst  A         B
    drive(1, 1, 4'h5, 4'h3, 1, 16'hAAAA, 16'hBBBB, 0, 0, 4'b0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 4'h0, 4'h0, 16'h0000, 16'h0000);
    drive(1, 1, 4'h5, 4'h3, 1, 16'hAAAA, 16'hBBBB, 0, 0, 4'b0000, 16'h0000, 16'h0000, 1, 0, 0, 0, 4'h0, 4'h0, 16'h0000, 16'h0000);
    drive(0, 1, 4'h1, 4'h2, 1, 16'h0011, 16'h0022, 0, 0, 4'b1000, 16'h0000, 16'h0000, 1, 0, 0, 0, 4'h0, 4'h0, 16'h0000, 16'h0000);
    // XX forward on A; next instruction has xx+mx on B
    drive(0, 1, 4'h2, 4'h4, 1, 16'h1111, 16'h2222, 0, 0, 4'b0011, 16'hBEEF, 16'h0000, 1, 0, 1, 1, 4'h1, 4'h2, 16'hBEEF, 16'h0022);
    // Priority XX over MX on B; stall issued this cycle
    drive(0, 1, 4'h3, 4'h5, 0, 16'h3333, 16'h4444, 1, 0, 4'b0000, 16'h1234, 16'h5678, 1, 1, 1, 1, 4'h2, 4'h4, 16'h1111, 16'h1234);
    // Bubble in EX; hazard unit now asserts mx1 for the consumer
    drive(0, 1, 4'h3, 4'h5, 0, 16'h3333, 16'h4444, 0, 0, 4'b0100, 16'h0000, 16'h0000, 1, 0, 0, 0, 4'h0, 4'h0, 16'h0000, 16'h0000);
    drive(0, 0, 4'h0, 4'h0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0000, 16'h1111, 16'hCAFE, 1, 0, 1, 0, 4'h3, 4'h5, 16'hCAFE, 16'h4444);
    // Flush plus stall: no hold
    drive(0, 1, 4'h7, 4'h6, 1, 16'h5555, 16'h6666, 1, 1, 4'b0000, 16'h0000, 16'h0000, 1, 0, 0, 0, 4'h0, 4'h0, 16'h0000, 16'h0000);
    // Two-cycle stall -> two bubbles
    drive(0, 1, 4'h8, 4'h7, 1, 16'h7777, 16'h8888, 1, 0, 4'b0000, 16'h0000, 16'h0000, 1, 1, 0, 0, 4'h0, 4'h0, 16'h0000, 16'h0000);
    drive(0, 1, 4'h8, 4'h7, 1, 16'h7777, 16'h8888, 1, 0, 4'b0000, 16'h0000, 16'h0000, 1, 1, 0, 0, 4'h0, 4'h0, 16'h0000, 16'h0000);
    drive(0, 1, 4'h8, 4'h7, 1, 16'h7777, 16'h8888, 0, 0, 4'b0000, 16'h0000, 16'h0000, 1, 0, 0, 0, 4'h0, 4'h0, 16'h0000, 16'h0000);
    drive(0, 0, 4'h0, 4'h0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0000, 16'h0000, 16'h0000, 1, 0, 1, 1, 4'h8, 4'h7, 16'h7777, 16'h8888);
    // Flush alone kills the ID instruction
    drive(0, 1, 4'h9, 4'h1, 1, 16'h9999, 16'hAAAA, 0, 1, 4'b0000, 16'h0000, 16'h0000, 1, 0, 0, 0, 4'h0, 4'h0, 16'h0000, 16'h0000);
    drive(0, 1, 4'hA, 4'h2, 1, 16'h0001, 16'h0002, 0, 0, 4'b0110, 16'h0000, 16'h0000, 1, 0, 0, 0, 4'h0, 4'h0, 16'h0000, 16'h0000);
`ifdef HAZARD_STATS_EN
    #2;
    check("stall_cnt", bus.stall_cnt, 16'd3);
    check("fwd_cnt",   bus.fwd_cnt,   16'd3);
`endif
    // Mid-operation reset with MX on A and XX on B live in EX
    drive(1, 1, 4'hB, 4'h3, 1, 16'h0003, 16'h0004, 0, 0, 4'b0000, 16'h3333, 16'h4444, 1, 0, 1, 1, 4'hA, 4'h2, 16'h4444, 16'h3333);
    // rf_wr gated by id_valid=0
    drive(0, 0, 4'hC, 4'h3, 1, 16'h00AB, 16'h00CD, 0, 0, 4'b0000, 16'h0005, 16'h0006, 1, 0, 0, 0, 4'h0, 4'h0, 16'h0000, 16'h0000);
    drive(0, 0, 4'h0, 4'h0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0000, 16'h0000, 16'h0000, 1, 0, 0, 0, 4'hC, 4'h3, 16'h00AB, 16'h00CD);
    drive(0, 0, 4'h0, 4'h0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0000, 16'h0000, 16'h0000, 1, 0, 0, 0, 4'h0, 4'h0, 16'h0000, 16'h0000);
`ifdef HAZARD_STATS_EN
    for (int i = 0; i < 65536; i++)
      drive(0, 0, 4'h0, 4'h0, 0, 16'h0000, 16'h0000, 1, 0, 4'b0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 4'h0, 4'h0, 16'h0000, 16'h0000);
    drive(0, 0, 4'h0, 4'h0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 4'h0, 4'h0, 16'h0000, 16'h0000);
    #2;
    check("stall_cnt_sat", bus.stall_cnt, 16'hFFFF);
`endif
    @(negedge clk);
    #4;
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
